dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the single-cycle RV32I core: the slave end of the core's load/store port. It holds the word-organised data RAM and serves the core's combinational read path. Stores commit on the clock edge. An optional memory-mapped page exposes a cycle counter, a store counter, an LED register and a compare/interrupt flag. It connects to the core by port name: `write`, `data_addr`, `data_out`, `data_in`.

## Interface
- `ADDR_W`, 10: RAM word-address width. Depth is 2^ADDR_W words.
- `MMIO_PAGE`, 16'h0001: value of `data_addr[31:16]` that selects the MMIO page.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `write` input 1: store strobe from the core; the store commits at the next rising `clk` edge.
- `data_addr` input 32: byte address from the core; bits [1:0] are ignored.
- `data_out` input 32: store data from the core.
- `data_in` output 32: load data to the core; combinational from `data_addr`.
- `led` output 8: LED register.
- `irq` output 1: compare-match flag, equal to STATUS[0].

## Operation
- Decode:
  - MMIO hit when the macro is enabled and `data_addr[31:16] == MMIO_PAGE`.
  - Otherwise RAM, at word index `data_addr[ADDR_W+1:2]`. Upper bits are ignored, so out-of-range addresses alias (wrap).
- RAM:
  - Asynchronous read.
  - Synchronous full-word write when `write` is 1 on a RAM address.
  - No reset; contents are unknown after power-up.
- MMIO registers, at word offset `data_addr[4:2]`:
  - 0x00 CYCLE (RO): free-running 32-bit counter, +1 every cycle, wraps FFFF_FFFF→0.
  - 0x04 STORES (RO): +1 per committed RAM store, saturates at FFFF_FFFF. MMIO stores are not counted.
  - 0x08 LED (RW): a write loads `data_out[7:0]`; reads return it zero-extended.
  - 0x0C CMP (RW): 32-bit compare value.
  - 0x10 STATUS (RW1C): bit0 MATCH.
    - Set at the edge where CYCLE (pre-increment) == CMP.
    - Writing `data_out[0]`=1 clears it.
    - If set and clear occur on the same edge, set wins.
    - Bits [31:1] read 0.
  - Offsets 0x14–0x1C: read 0; writes are ignored.
  - Writes to RO registers are ignored.
- Reads have no side effects. The core may present any address, including X/Z, while no load or store is active, so reads must never alter state.
- An X/Z address with `write`=0 has no effect on state; `data_in` is don't-care.
- Reset (`rst_n`=0, asynchronous, any time including mid-store):
  - CYCLE, STORES, LED, CMP, STATUS are cleared to 0.
  - A store whose edge coincides with active reset is dropped.
  - RAM is untouched.

## Timing
- Load latency 0: `data_in` follows `data_addr` and RAM/register contents combinationally within the same cycle.
- Store latency 1: the new value is visible on `data_in` immediately after the committing edge.
- Read-during-write to the same address: `data_in` shows old data until the edge, new data after it.
- CYCLE reads 0 in the first cycle after reset release, and N after N edges.
- `irq` is registered; it rises in the cycle after the matching edge.
- Output reset values: `led`=0, `irq`=0. `data_in` has no reset value because it is combinational.

## Configuration
- Macro `DMEM_MMIO_EN`.
- Defined: MMIO page decoded as specified above.
- Undefined:
  - No MMIO registers or counters are built.
  - Every address maps to RAM, including the `MMIO_PAGE` range (aliased).
  - `led` and `irq` are tied to 0.

## Structure
- Package `dmem_pkg` holds:
  - register offset constants `OFF_CYCLE`, `OFF_STORES`, `OFF_LED`, `OFF_CMP`, `OFF_STATUS`;
  - default `MMIO_PAGE`;
  - STATUS bit index `ST_MATCH`;
  - `LED_W`=8.
- Sub-module `dmem_ram`: parameterised by `ADDR_W`; single port, synchronous write, asynchronous read, no reset.
- The top level contains decode, the MMIO register block under the macro, and the read mux.

## Test plan
- Store then load: write 0xDEADBEEF to 0x0000_0010 → `data_in`=0xDEADBEEF after the edge. Address 0x0000_1010 (ADDR_W=10) aliases to the same word.
- Counters: release reset, idle 5 cycles, read 0x0001_0000 → 5. Three RAM stores plus one LED store → STORES=3.
- Compare: CMP=20 → `irq` rises in cycle 21. Writing STATUS=1 on a non-matching edge clears it. A clear coinciding with a match leaves it set.
- LED: store 0x1234_56A5 to 0x0001_0008 → `led`=0xA5, read returns 0x0000_00A5. A store to 0x0001_0000 leaves CYCLE unaffected.
- Reset mid-operation: assert `rst_n`=0 while `write`=1 → LED/CMP/STATUS/counters are 0 and the stored word is unchanged. Previously written RAM data is preserved.
- Macro undefined: a store to 0x0001_0008 lands in RAM word 2. `led`, `irq` stay 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data-memory responder.
// Register offsets are word offsets taken from data_addr[4:2].
package dmem_pkg;

  // Default upper-halfword of the address that selects the MMIO page
  localparam logic [15:0] DEF_MMIO_PAGE = 16'h0001;

  // MMIO register word offsets
  localparam logic [2:0] OFF_CYCLE  = 3'd0;
  localparam logic [2:0] OFF_STORES = 3'd1;
  localparam logic [2:0] OFF_LED    = 3'd2;
  localparam logic [2:0] OFF_CMP    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  // STATUS bit holding the compare-match flag
  localparam int ST_MATCH = 0;

  // Width of the LED register
  localparam int LED_W = 8;

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port word RAM, synchronous write, asynchronous read.
// Contents are deliberately not reset so the array maps onto plain memory.
module dmem_ram #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];

  // Commit a full-word store on the rising edge
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the RV32I core's load/store port.
// Holds the data RAM and, when DMEM_MMIO_EN is defined, a small MMIO page
// with CYCLE, STORES, LED, CMP and STATUS registers. With DMEM_MMIO_EN
// undefined every address maps to RAM and led/irq are tied to zero.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [15:0] MMIO_PAGE = DEF_MMIO_PAGE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_out,
  output logic [31:0]      data_in,
  output logic [LED_W-1:0] led,
  output logic             irq
);

  logic [ADDR_W-1:0] wordIdx;
  logic [31:0]       ramRdata;
  logic              ramWe;
  logic              unusedAddrBits;

  // RAM word index; upper address bits alias and byte-lane bits are ignored
  assign wordIdx        = data_addr[ADDR_W+1:2];
  assign unusedAddrBits = ^{data_addr[31:ADDR_W+2], data_addr[1:0]};

  dmem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ramWe),
    .addr_i  (wordIdx),
    .wdata_i (data_out),
    .rdata_o (ramRdata)
  );

`ifdef DMEM_MMIO_EN

  logic             mmioHit;
  logic             mmioWe;
  logic [2:0]       regOff;
  logic [31:0]      cycle_q, cycle_d;
  logic [31:0]      stores_q, stores_d;
  logic [31:0]      cmp_q, cmp_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             match_q, match_d;

  // A store that coincides with active reset must not reach the RAM
  assign mmioHit = (data_addr[31:16] == MMIO_PAGE);
  assign regOff  = data_addr[4:2];
  assign mmioWe  = write && mmioHit;
  assign ramWe   = write && !mmioHit && rst_n;

  // Next-state for the MMIO registers; a match on the same edge beats a clear
  always_comb begin
    cycle_d  = cycle_q + 32'd1;
    stores_d = stores_q;
    led_d    = led_q;
    cmp_d    = cmp_q;
    match_d  = match_q;
    if (ramWe && (stores_q != 32'hFFFF_FFFF)) begin
      stores_d = stores_q + 32'd1;
    end
    if (mmioWe) begin
      case (regOff)
        OFF_LED:    led_d = data_out[LED_W-1:0];
        OFF_CMP:    cmp_d = data_out;
        OFF_STATUS: if (data_out[ST_MATCH]) match_d = 1'b0;
        default:    ;
      endcase
    end
    if (cycle_q == cmp_q) begin
      match_d = 1'b1;
    end
  end

  // MMIO register state with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q  <= '0;
      stores_q <= '0;
      led_q    <= '0;
      cmp_q    <= '0;
      match_q  <= 1'b0;
    end else begin
      cycle_q  <= cycle_d;
      stores_q <= stores_d;
      led_q    <= led_d;
      cmp_q    <= cmp_d;
      match_q  <= match_d;
    end
  end

  // Combinational load path: MMIO register or RAM word
  always_comb begin
    data_in = ramRdata;
    if (mmioHit) begin
      data_in = '0;
      case (regOff)
        OFF_CYCLE:  data_in = cycle_q;
        OFF_STORES: data_in = stores_q;
        OFF_LED:    data_in[LED_W-1:0] = led_q;
        OFF_CMP:    data_in = cmp_q;
        OFF_STATUS: data_in[ST_MATCH] = match_q;
        default:    data_in = '0;
      endcase
    end
  end

  assign led = led_q;
  assign irq = match_q;

`else

  logic unusedPage;

  // Without the MMIO page every store goes to RAM
  assign ramWe      = write && rst_n;
  assign data_in    = ramRdata;
  assign led        = '0;
  assign irq        = 1'b0;
  assign unusedPage = ^MMIO_PAGE;

`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder.
// Directed scenarios plus randomized traffic, checked every cycle against a
// behavioural model of the memory and MMIO page. Follows DMEM_MMIO_EN.
module tb_dmem_responder;

  localparam int ADDR_W = 10;
  localparam int WORDS  = 2**ADDR_W;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write;
  logic [31:0] data_addr;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic [7:0]  led;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] mRam   [WORDS];
  bit          mValid [WORDS];
  logic [31:0] mCycle;
  logic [31:0] mStores;
  logic [31:0] mCmp;
  logic [7:0]  mLed;
  bit          mMatch;

  dmem_responder #(
    .ADDR_W    (ADDR_W),
    .MMIO_PAGE (16'h0001)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .write     (write),
    .data_addr (data_addr),
    .data_out  (data_out),
    .data_in   (data_in),
    .led       (led),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  function automatic bit isMmio(input logic [31:0] a);
`ifdef DMEM_MMIO_EN
    return a[31:16] == 16'h0001;
`else
    return 1'b0;
`endif
  endfunction

  task automatic resetModel();
    mCycle  = 0;
    mStores = 0;
    mCmp    = 0;
    mLed    = 0;
    mMatch  = 0;
  endtask

  // What a load from address a must return, if the model knows it
  task automatic modelRead(input logic [31:0] a, output bit known, output logic [31:0] v);
    int idx;
    known = 0;
    v     = 0;
    if ($isunknown(a)) return;
    if (isMmio(a)) begin
      known = 1;
      case (a[4:2])
        3'd0:    v = mCycle;
        3'd1:    v = mStores;
        3'd2:    v = {24'd0, mLed};
        3'd3:    v = mCmp;
        3'd4:    v = {31'd0, mMatch};
        default: v = 0;
      endcase
    end else begin
      idx = int'(a[ADDR_W+1:2]);
      if (mValid[idx]) begin
        known = 1;
        v     = mRam[idx];
      end
    end
  endtask

  // Asynchronous reset clears the registers but never the RAM
  always @(negedge rst_n) resetModel();

  // Advance the model at each rising edge using the inputs held across it
  always @(posedge clk) begin
    bit matchNow;
    bit clr;
    int idx;
    if (rst_n === 1'b1) begin
      matchNow = (mCycle == mCmp);
      clr      = 0;
      if (write === 1'b1) begin
        if (isMmio(data_addr)) begin
          case (data_addr[4:2])
            3'd2:    mLed = data_out[7:0];
            3'd3:    mCmp = data_out;
            3'd4:    clr  = data_out[0];
            default: ;
          endcase
        end else begin
          idx         = int'(data_addr[ADDR_W+1:2]);
          mRam[idx]   = data_out;
          mValid[idx] = 1;
          if (mStores != 32'hFFFF_FFFF) mStores = mStores + 1;
        end
      end
      mMatch = matchNow || (mMatch && !clr);
      mCycle = mCycle + 1;
    end
  end

  task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    bit          known;
    logic [31:0] exp;
`ifdef DMEM_MMIO_EN
    compareValue("led", {24'd0, led}, {24'd0, mLed});
    compareValue("irq", {31'd0, irq}, {31'd0, mMatch});
`else
    compareValue("led", {24'd0, led}, 32'd0);
    compareValue("irq", {31'd0, irq}, 32'd0);
`endif
    modelRead(data_addr, known, exp);
    if (known) compareValue("data_in", data_in, exp);
  endtask

  // Compare process: outputs are checked mid-cycle, away from the edge
  always @(negedge clk) begin
    #2;
    checkOutput();
  end

  // Drive one cycle of inputs, starting at a falling edge
  task automatic applyStimulus(input bit rstN, input bit w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rst_n     = rstN;
    write     = w;
    data_addr = a;
    data_out  = d;
    #3;
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    for (int i = 0; i < WORDS; i++) mValid[i] = 0;
    resetModel();
    rst_n     = 1'b0;
    write     = 1'b0;
    data_addr = 32'h0;
    data_out  = 32'h0;

    // Reset state
    repeat (3) applyStimulus(0, 0, 32'h0, 32'h0);
    compareValue("reset_led", {24'd0, led}, 32'd0);
    compareValue("reset_irq", {31'd0, irq}, 32'd0);

    // Release reset, idle, then CYCLE must read 5
    applyStimulus(1, 0, 32'h0, 32'h0);
    repeat (4) applyStimulus(1, 0, 32'h0, 32'h0);
    applyStimulus(1, 0, 32'h0001_0000, 32'h0);
`ifdef DMEM_MMIO_EN
    compareValue("cycle_after_5", data_in, 32'd5);
`endif

    // Store then load, and an aliased address reaching the same word
    applyStimulus(1, 1, 32'h0000_0010, 32'hDEAD_BEEF);
    applyStimulus(1, 0, 32'h0000_0010, 32'h0);
    compareValue("load_after_store", data_in, 32'hDEAD_BEEF);
    applyStimulus(1, 0, 32'h0000_1010, 32'h0);
    compareValue("alias_load", data_in, 32'hDEAD_BEEF);

    // Two more RAM stores and one LED store
    applyStimulus(1, 1, 32'h0000_0014, 32'hCAFE_F00D);
    applyStimulus(1, 1, 32'h0000_0FFC, 32'h0123_4567);
    applyStimulus(1, 1, 32'h0001_0008, 32'h1234_56A5);
    applyStimulus(1, 0, 32'h0001_0008, 32'h0);
`ifdef DMEM_MMIO_EN
    compareValue("led_value", {24'd0, led}, 32'h0000_00A5);
    compareValue("led_read", data_in, 32'h0000_00A5);
    applyStimulus(1, 0, 32'h0001_0004, 32'h0);
    compareValue("stores_3", data_in, 32'd3);
`else
    compareValue("led_tied", {24'd0, led}, 32'd0);
    compareValue("page_alias_read", data_in, 32'h1234_56A5);
    applyStimulus(1, 0, 32'h0000_0008, 32'h0);
    compareValue("ram_word2", data_in, 32'h1234_56A5);
`endif

    // A store to CYCLE is ignored; the model keeps counting
    applyStimulus(1, 1, 32'h0001_0000, 32'hFFFF_0000);
    applyStimulus(1, 0, 32'h0001_0000, 32'h0);

    // Compare/interrupt sequence from a fresh reset
    repeat (2) applyStimulus(0, 0, 32'h0, 32'h0);
    applyStimulus(1, 1, 32'h0001_000C, 32'd20);
    applyStimulus(1, 1, 32'h0001_0010, 32'd1);
`ifdef DMEM_MMIO_EN
    compareValue("irq_reset_match", {31'd0, irq}, 32'd1);
`endif
    for (int c = 2; c <= 20; c++) applyStimulus(1, 0, 32'h0001_0010, 32'h0);
    compareValue("irq_cycle20", {31'd0, irq}, 32'd0);
    applyStimulus(1, 0, 32'h0001_0010, 32'h0);
`ifdef DMEM_MMIO_EN
    compareValue("irq_cycle21", {31'd0, irq}, 32'd1);
    compareValue("status_read", data_in, 32'd1);
`else
    compareValue("irq_tied", {31'd0, irq}, 32'd0);
`endif
    applyStimulus(1, 1, 32'h0001_0010, 32'd1);
    applyStimulus(1, 1, 32'h0001_000C, 32'd26);
    applyStimulus(1, 0, 32'h0, 32'h0);
    compareValue("irq_cleared", {31'd0, irq}, 32'd0);
    applyStimulus(1, 0, 32'h0, 32'h0);
    applyStimulus(1, 1, 32'h0001_0010, 32'd1);
    compareValue("irq_before_tie", {31'd0, irq}, 32'd0);
    applyStimulus(1, 0, 32'h0, 32'h0);
`ifdef DMEM_MMIO_EN
    compareValue("irq_set_wins", {31'd0, irq}, 32'd1);
`endif

    // Reset during a store: the store is dropped and RAM survives
    applyStimulus(1, 1, 32'h0000_0010, 32'hDEAD_BEEF);
    applyStimulus(0, 1, 32'h0000_0010, 32'h1111_1111);
    applyStimulus(0, 0, 32'h0, 32'h0);
    applyStimulus(1, 0, 32'h0000_0010, 32'h0);
    compareValue("reset_store_dropped", data_in, 32'hDEAD_BEEF);
    compareValue("reset_led_clear", {24'd0, led}, 32'd0);
    applyStimulus(1, 0, 32'h0000_0014, 32'h0);
    compareValue("ram_preserved", data_in, 32'hCAFE_F00D);

    // Randomized traffic over RAM, aliases, the MMIO page and idle X addresses
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 50) begin
        a = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      end else begin
        a = 32'h0001_0000 | (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 7)) << 2);
      end
      if (r == 99) begin
        applyStimulus(0, 1, a, $urandom());
      end else if (r < 5) begin
        applyStimulus(1, 0, 32'hx, $urandom());
      end else begin
        applyStimulus(1, ($urandom_range(0, 2) == 0), a, $urandom());
      end
    end
    applyStimulus(1, 0, 32'h0, 32'h0);
    applyStimulus(1, 0, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
